// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, bit functions, FSM states.
package sha256_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  typedef enum logic [2:0] {IDLE, RND0, FIN0, RND1, FIN1, DONE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam work_t IV = work_t'({32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19});

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Field-wise mod-2^32 sum used for the intermediate hash update.
  function automatic work_t add_work(input work_t x, input work_t y);
    return '{a: x.a + y.a, b: x.b + y.b, c: x.c + y.c, d: x.d + y.d,
             e: x.e + y.e, f: x.f + y.f, g: x.g + y.g, h: x.h + y.h};
  endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational SHA-256 compression round: (a..h, K_t, W_t) -> next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1  = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
  assign t2  = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);
  assign nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
                 e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};

endmodule

// File: rtl/sha256_1024_in.sv
// SHA-256 over one pre-padded 1024-bit message (two blocks) to a 256-bit digest.
// Define SHA256_2ROUND_EN to run two chained rounds per cycle (66-cycle latency instead of 130).
module sha256_1024_in
  import sha256_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid,
  input  logic [1023:0] in,
  output logic          in_ready,
  output logic          out_valid,
  output logic [255:0]  out,
  input  logic          out_ready
);

`ifdef SHA256_2ROUND_EN
  localparam logic [5:0] STEP   = 6'd2;
  localparam logic [5:0] LAST_T = 6'd62;
`else
  localparam logic [5:0] STEP   = 6'd1;
  localparam logic [5:0] LAST_T = 6'd63;
`endif

  state_t       state, state_nxt;
  logic [5:0]   t;
  work_t        hv, work, work_nxt, hv_sum;
  logic [31:0]  w     [16];
  logic [31:0]  w_nxt [16];
  logic [511:0] blk1;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign hv_sum    = add_work(hv, work);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every variable written here is defaulted first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RND0;
      RND0:    if (t == LAST_T) state_nxt = FIN0;
      FIN0:    state_nxt = RND1;
      RND1:    if (t == LAST_T) state_nxt = FIN1;
      FIN1:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SHA256_2ROUND_EN
  work_t mid;

  sha256_round u_round0 (.cur(work), .k(K[t]),         .w(w[0]), .nxt(mid));
  sha256_round u_round1 (.cur(mid),  .k(K[t | 6'd1]),  .w(w[1]), .nxt(work_nxt));

  // Window slides two words; the second new word depends only on words already held.
  always_comb begin
    for (int i = 0; i < 14; i++) w_nxt[i] = w[i+2];
    w_nxt[14] = ssig1(w[14]) + w[9]  + ssig0(w[1]) + w[0];
    w_nxt[15] = ssig1(w[15]) + w[10] + ssig0(w[2]) + w[1];
  end
`else
  sha256_round u_round0 (.cur(work), .k(K[t]), .w(w[0]), .nxt(work_nxt));

  always_comb begin
    for (int i = 0; i < 15; i++) w_nxt[i] = w[i+1];
    w_nxt[15] = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  end
`endif

  // NOTE: the W window is a small register file, not RAM, so it is cleared on reset with the rest.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      t    <= '0;
      hv   <= '0;
      work <= '0;
      blk1 <= '0;
      out  <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          blk1 <= in[511:0];
          hv   <= IV;
          work <= IV;
          t    <= '0;
          for (int i = 0; i < 16; i++) w[i] <= in[1023 - 32*i -: 32];
        end
        RND0, RND1: begin
          work <= work_nxt;
          w    <= w_nxt;
          t    <= t + STEP;
        end
        FIN0: begin
          hv   <= hv_sum;
          work <= hv_sum;
          t    <= '0;
          for (int i = 0; i < 16; i++) w[i] <= blk1[511 - 32*i -: 32];
        end
        FIN1: begin
          hv  <= hv_sum;
          out <= hv_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_1024_in.sv
// Self-checking bench for sha256_1024_in: vector table, scoreboard queue, and handshake/reset corner sequences.
module tb_sha256_1024_in;

`ifdef SHA256_2ROUND_EN
  localparam int LAT = 66;
  localparam int MID = 50;
`else
  localparam int LAT = 130;
  localparam int MID = 100;
`endif

  localparam logic [255:0] ABC_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] TIV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef struct {
    logic [1023:0] msg;
    logic [255:0]  exp;
    int            hold;
    bit            noise;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid;
  logic [1023:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [255:0]  out_data;
  logic          out_ready;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [255:0]  sb [$];
  logic [255:0]  last_out;

  sha256_1024_in dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_valid (in_valid),
    .in       (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out      (out_data),
    .out_ready(out_ready)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Straight textbook SHA-256 compression over both blocks with a full 64-word schedule.
  function automatic logic [255:0] model(input logic [1023:0] m);
    logic [31:0] hh [8];
    logic [31:0] ws [64];
    logic [31:0] v  [8];
    logic [31:0] x, y;
    for (int i = 0; i < 8; i++) hh[i] = TIV[i];
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) ws[i] = m[1023 - 512*b - 32*i -: 32];
      for (int i = 16; i < 64; i++)
        ws[i] = (rr(ws[i-2], 17) ^ rr(ws[i-2], 19) ^ (ws[i-2] >> 10)) + ws[i-7]
              + (rr(ws[i-15], 7) ^ rr(ws[i-15], 18) ^ (ws[i-15] >> 3)) + ws[i-16];
      for (int i = 0; i < 8; i++) v[i] = hh[i];
      for (int i = 0; i < 64; i++) begin
        x = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
          + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[i] + ws[i];
        y = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
          + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x;
        v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x + y;
      end
      for (int i = 0; i < 8; i++) hh[i] = hh[i] + v[i];
    end
    return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, presents the message for one accepting edge, records the expected digest.
  task automatic send(input logic [1023:0] m, input logic [255:0] e);
    int k;
    k = 0;
    @(negedge clk_i);
    while (!in_ready && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    check("accept_ready", 256'(in_ready), 256'd1);
    in_valid = 1'b1;
    in_data  = m;
    @(posedge clk_i);
    sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; optionally jabs the inputs while busy.
  task automatic wait_out(input bit noise, output int n, output bit busy_ok, output bit held_ok);
    n = 0; busy_ok = 1'b1; held_ok = 1'b1;
    while (n < 400) begin
      @(negedge clk_i);
      if (in_ready) busy_ok = 1'b0;
      if (out_data !== last_out) held_ok = 1'b0;
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = rand1024();
        out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk_i);
      n++;
      #1;
      if (out_valid) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Called just after out_valid rose: compare, optionally stall, then handshake.
  task automatic receive(input int hold, input bit noise);
    logic [255:0] e, snap;
    bit           stable_ok;
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    check("digest", out_data, e);
    snap = out_data;
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      if (!out_valid || out_data !== snap || in_ready) stable_ok = 1'b0;
      if (noise) begin
        in_valid = 1'b1;
        in_data  = rand1024();
      end
    end
    if (hold > 0) check("done_hold", 256'(stable_ok), 256'd1);
    @(negedge clk_i);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk_i);
    #1 out_ready = 1'b0;
    check("ov_drop", 256'(out_valid), 256'd0);
    check("idle_after", 256'(in_ready), 256'd1);
    check("out_keep", out_data, snap);
    last_out = snap;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs [5];
    logic [447:0]  s;
    logic [1023:0] abc, rmsg;
    int            n;
    bit            busy_ok, held_ok;

    s    = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    abc  = {s, 8'h80, 56'h0, 448'h0, 64'd448};
    rmsg = rand1024();
    vecs[0] = '{msg: abc,       exp: ABC_DIGEST,    hold: 0,  noise: 1'b0};
    vecs[1] = '{msg: abc,       exp: ABC_DIGEST,    hold: 20, noise: 1'b1};
    vecs[2] = '{msg: '0,        exp: model('0),     hold: 3,  noise: 1'b1};
    vecs[3] = '{msg: rmsg,      exp: model(rmsg),   hold: 1,  noise: 1'b0};
    vecs[4] = '{msg: '1,        exp: model('1),     hold: 0,  noise: 1'b1};

    rst_i = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    last_out = '0;
    repeat (2) @(negedge clk_i);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_in_ready",  256'(in_ready),  256'd1);
    check("rst_out",       out_data,        256'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].msg, vecs[i].exp);
      wait_out(vecs[i].noise, n, busy_ok, held_ok);
      check("latency",       256'(n),       256'(LAT));
      check("busy_in_ready", 256'(busy_ok), 256'd1);
      check("out_held",      256'(held_ok), 256'd1);
      receive(vecs[i].hold, vecs[i].noise);
    end

    // Back-to-back: in_valid held across the out handshake is accepted only one cycle later.
    send(abc, ABC_DIGEST);
    wait_out(1'b0, n, busy_ok, held_ok);
    check("b2b_latency", 256'(n), 256'(LAT));
    check("b2b_first", out_data, sb.pop_front());
    last_out = out_data;
    @(negedge clk_i);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = '0;
    @(posedge clk_i);
    #1;
    check("b2b_no_same_cycle", 256'(in_ready),  256'd1);
    check("b2b_ov_drop",       256'(out_valid), 256'd0);
    @(posedge clk_i);
    sb.push_back(model('0));
    #1 in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepted", 256'(in_ready), 256'd0);
    wait_out(1'b0, n, busy_ok, held_ok);
    check("b2b2_latency", 256'(n), 256'(LAT));
    check("b2b_first_kept", 256'(held_ok), 256'd1);
    receive(0, 1'b0);

    // Asynchronous reset in the second block aborts the hash without flagging a digest.
    send(rmsg, model(rmsg));
    held_ok = 1'b1;
    for (int i = 0; i < MID; i++) begin
      @(posedge clk_i);
      #1 if (out_valid) held_ok = 1'b0;
    end
    check("mid_no_valid", 256'(held_ok), 256'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("abort_out_valid", 256'(out_valid), 256'd0);
    check("abort_in_ready",  256'(in_ready),  256'd1);
    check("abort_out",       out_data,        256'd0);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    last_out = '0;
    send(abc, ABC_DIGEST);
    wait_out(1'b0, n, busy_ok, held_ok);
    check("post_rst_latency", 256'(n), 256'(LAT));
    receive(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
